// File: rtl/pwm_pkg.sv
// Shared register map, counter mode encoding and ctrl bit layout for the PWM block.
package pwm_pkg;

    localparam int unsigned ADDR_PERIOD = 0;
    localparam int unsigned ADDR_CTRL   = 1;
    localparam int unsigned ADDR_DUTY0  = 2;

    typedef enum logic {
        ModeEdge   = 1'b0,
        ModeCenter = 1'b1
    } pwm_mode_e;

    localparam int unsigned CTRL_MODE_BIT = 0;
    localparam int unsigned CTRL_EN_LSB   = 1;

    // Polarity field sits directly above the per-channel enable field.
    function automatic int unsigned ctrl_pol_lsb(input int unsigned num_ch);
        return CTRL_EN_LSB + num_ch;
    endfunction

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: duty compare against the shared counter, enable/polarity, output flop.
module pwm_channel_cmp #(
    parameter int unsigned CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W-1:0] i_duty,
    input  logic             i_en,
    input  logic             i_pol,
    output logic             o_pwm
);

    logic w_raw;
    logic r_pwm;

    assign w_raw = (i_cnt < i_duty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= i_en ? (w_raw ^ i_pol) : i_pol;
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_multichannel.sv
// Multichannel PWM: shared edge/center-aligned counter with shadowed period, duty and
// mode that commit together at a period boundary.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 12,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic              out_en,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);

    localparam int unsigned PolLsb = ctrl_pol_lsb(NUM_CH);

    logic [CNT_W-1:0]  r_period_sh, r_period_act;
    logic [CNT_W-1:0]  r_duty_sh  [NUM_CH];
    logic [CNT_W-1:0]  r_duty_act [NUM_CH];
    pwm_mode_e         r_mode_sh, r_mode_act;
    logic [NUM_CH-1:0] r_en, r_pol;
    logic [CNT_W-1:0]  r_cnt, w_cnt_d, w_last;
    logic              r_dir, w_dir_d;
    logic              r_pending, r_bnd, r_tick;
    logic              w_idle, w_boundary, w_load, w_shadow_wr;
    int unsigned       w_addr;

    assign w_addr      = 32'(wr_addr);
    assign w_last      = r_period_act - CNT_W'(1);
    assign w_shadow_wr = wr_en && ((w_addr == ADDR_PERIOD) || (w_addr == ADDR_CTRL) ||
                         ((w_addr >= ADDR_DUTY0) && (w_addr < ADDR_DUTY0 + NUM_CH)));

    // r_dir = 1 while counting down (center mode only).
    always_comb begin
        w_cnt_d    = r_cnt;
        w_dir_d    = r_dir;
        w_boundary = 1'b0;
        w_idle     = (r_period_act == '0);
        if (w_idle) begin
            w_cnt_d = '0;
            w_dir_d = 1'b0;
        end else if (r_mode_act == ModeEdge) begin
            if (r_cnt >= w_last) begin
                w_boundary = 1'b1;
                w_cnt_d    = '0;
            end else begin
                w_cnt_d = r_cnt + CNT_W'(1);
            end
        end else if (r_dir || (r_cnt >= w_last)) begin
            // Turnaround and boundary coincide when the top count is 0 or 1 (P = 1, 2).
            if (r_cnt <= CNT_W'(1)) begin
                w_boundary = 1'b1;
                w_cnt_d    = '0;
                w_dir_d    = 1'b0;
            end else begin
                w_cnt_d = r_cnt - CNT_W'(1);
                w_dir_d = 1'b1;
            end
        end else begin
            w_cnt_d = r_cnt + CNT_W'(1);
        end
        w_load = r_pending && (w_idle || w_boundary);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_sh  <= '0;
            r_period_act <= '0;
            r_mode_sh    <= ModeEdge;
            r_mode_act   <= ModeEdge;
            r_en         <= '0;
            r_pol        <= '0;
            r_cnt        <= '0;
            r_dir        <= 1'b0;
            r_pending    <= 1'b0;
            r_bnd        <= 1'b0;
            r_tick       <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_duty_sh[k]  <= '0;
                r_duty_act[k] <= '0;
            end
        end else begin
            r_cnt  <= w_cnt_d;
            r_dir  <= w_dir_d;
            r_bnd  <= w_boundary;
            r_tick <= r_bnd;
            if (wr_en && (w_addr == ADDR_PERIOD)) begin
                r_period_sh <= wr_data;
            end
            if (wr_en && (w_addr == ADDR_CTRL)) begin
                r_mode_sh <= pwm_mode_e'(wr_data[CTRL_MODE_BIT]);
                r_en      <= wr_data[CTRL_EN_LSB +: NUM_CH];
                r_pol     <= wr_data[PolLsb +: NUM_CH];
            end
            // A write landing on the load cycle keeps the flag set for the next boundary.
            if (w_load) begin
                r_period_act <= r_period_sh;
                r_mode_act   <= r_mode_sh;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_en && (w_addr == ADDR_DUTY0 + k)) begin
                    r_duty_sh[k] <= wr_data;
                end
                if (w_load) begin
                    r_duty_act[k] <= r_duty_sh[k];
                end
            end
            if (w_shadow_wr) begin
                r_pending <= 1'b1;
            end else if (w_load) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign period_tick = r_tick;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel_cmp #(
            .CNT_W(CNT_W)
        ) u_cmp (
            .clk   (clk),
            .rst_n (rst_n),
            .i_cnt (r_cnt),
            .i_duty(r_duty_act[g]),
            .i_en  (out_en & r_en[g]),
            .i_pol (r_pol[g]),
            .o_pwm (pwm_out[g])
        );
    end

endmodule
